alu_bist: RTL and testbench
===========================

// Module: alu_bist
// PURPOSE
//  Synthesisable built-in self-test sequencer for the ALU.
//  - Steps through every alu_control_t op. For each op it applies all N_VEC x N_VEC directed (a,b) pairs, then N_RAND LFSR pairs.
//  - Drives one shared stimulus bus to the DUT ALU and to alu_behavioural, then compares result/overflow/zero/equal every cycle.
//  - Keeps total and per-op error counts, and aborts early once the error count exceeds MAX_ERR.
//  - Sits beside the ALU on the FPGA top level; start comes from a button or host, and pass/done go to LEDs.
// PARAMETERS
//  N        32            datapath width (ALU operand/result width)
//  N_VEC    10            number of directed vectors (package constant ALU_BIST_VECTORS[0:N_VEC-1])
//  N_RAND   1000          random pairs per op
//  MAX_ERR  10            abort when err_total > MAX_ERR
//  SEED     32'hACE1_2021 LFSR reset/start value; must be nonzero
//  CW       16            error counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-low reset
//  start        in   1        one-cycle pulse; begins a run when not busy
//  busy         out  1        run in progress
//  done         out  1        run finished (complete or aborted); sticky until next start
//  pass         out  1        valid when done: 1 iff err_total==0
//  aborted      out  1        valid when done: run stopped on MAX_ERR
//  a, b         out  N        stimulus to both ALUs (registered)
//  control      out  alu_control_t  op to both ALUs (registered)
//  dut_result   in   N        DUT result; dut_overflow/dut_zero/dut_equal in 1 each
//  ref_result   in   N        golden result; ref_overflow/ref_zero/ref_equal in 1 each
//  err_total    out  CW       total mismatches (saturating)
//  err_sel      in   4        op index whose count appears on err_op_count
//  err_op_count out  CW       per-op result-mismatch count for err_sel (combinational read)
// BEHAVIOUR
//  Reset (rst==0, async):
//   - state=IDLE; all outputs 0; control=first op.
//   - All counters 0; LFSR=SEED.
//   - Reset mid-run abandons the run and clears everything; no done pulse follows.
//  States:
//   - IDLE -start-> DIR. Clears counters and per-op counters; LFSR=SEED; op index=0; j=k=0.
//   - DIR: a=VEC[j], b=VEC[k]. k increments first, then j. After j=k=N_VEC-1 -> RAND.
//   - RAND: a, b = successive LFSR words (a then b; LFSR steps twice per cycle). After N_RAND cycles -> NXT.
//   - NXT: if op==last -> DRAIN, else op=next, j=k=0 -> DIR.
//   - DRAIN: one cycle so the final compare is counted -> DONE.
//   - DONE: done=1, busy=0. start -> DIR (new run). No other exit.
//  Ops: iterate alu_control_t from .first to .last via .next; the behaviour must not depend on how many ops exist.
//  Timing: one vector per cycle. a/b/control are registered at edge t. The ALUs are combinational, so the compare at edge t+1 samples the outputs for vector t.
//  Compare, per vector, using !== so X/Z count as mismatches:
//   - err_total increments by the number of mismatching fields among zero, equal, overflow and result (0..4).
//   - The per-op counter for the current control increments by 1 only on a result mismatch.
//  Counters saturate at 2^CW-1.
//  Abort: when err_total > MAX_ERR after an update, go to DONE next cycle with aborted=1. The vector already in flight is not counted.
//  start while busy is ignored. start in the same cycle as the final compare is ignored.
//  LFSR: 32-bit Galois, taps 32,22,2,1.
//   - For N<32, use the low N bits.
//   - For N>32, concatenate successive words.
//   - Never reloads during a run.
// STRUCTURE
//  Package alu_bist_pkg:
//   - bist_state_t enum {IDLE,DIR,RAND,NXT,DRAIN,DONE}
//   - ALU_BIST_VECTORS constant array (0, 1, -1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA, 31, 32, 32'hFFFF_FFFE)
//   - LFSR tap constant
//  alu_control_t comes from the existing alu_types.sv.
//  Sub-module alu_bist_lfsr: N-wide output, step input, SEED parameter, async active-low reset.
//  Per-op counters: array indexed by the control encoding; unused entries stay 0.
// TESTING
//  Bench wraps alu_bist around alu (DUT) and alu_behavioural, and also around a fault-injected DUT.
//  1. Good DUT, start pulse -> busy for ops*(N_VEC^2+N_RAND+1)+1 cycles, then done=1, pass=1, aborted=0, err_total=0.
//  2. DUT with result forced to 0 for ADD only -> aborted=1 and err_total=MAX_ERR+1 or more (counts only, with saturation). Per-op count is nonzero for ADD and 0 for every other op.
//  3. DUT with zero flag stuck at 0, MAX_ERR=1000 -> run completes, pass=0. err_total equals the number of vectors whose golden zero==1. All per-op counts are 0.
//  4. Reset low at cycle 500 of a run -> all outputs 0 within the same cycle. A later start reruns with an identical stimulus sequence: a/b trace matches a fresh run.
//  5. start pulsed while busy, and in the final-compare cycle -> ignored; exactly one done rise.
//  6. CW=4 with an always-wrong DUT and MAX_ERR=100 -> err_total saturates at 15; aborted=0; done occurs.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Types and constants for the ALU built-in self-test sequencer.
package alu_bist_pkg;

   typedef enum logic [2:0] {IDLE, DIR, RAND, NXT, DRAIN, DONE} bist_state_t;

   localparam int unsigned N_VEC = 10;

   localparam logic [31:0] ALU_BIST_VECTORS [0:N_VEC-1] = '{
      32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
      32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_001F, 32'h0000_0020, 32'hFFFF_FFFE
   };

   // Right-shifting Galois toggle mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/alu_types.sv
// ALU operation encoding shared by the ALU, its behavioural model and the BIST sequencer.
package alu_types_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'h0,
      ALU_OR  = 4'h1,
      ALU_ADD = 4'h2,
      ALU_SUB = 4'h6,
      ALU_XOR = 4'h7,
      ALU_NOR = 4'hC
   } alu_control_t;

endpackage

// File: rtl/alu_bist_lfsr.sv
// Random operand source: a and b are successive 32-bit LFSR words (several words each when N > 32).
module alu_bist_lfsr
   import alu_bist_pkg::*;
#(
   parameter int unsigned N    = 32,
   parameter logic [31:0] SEED = 32'hACE1_2021
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   output logic [N-1:0] rnd_a_c,
   output logic [N-1:0] rnd_b_c
);

   localparam int unsigned WORDS = (N + 31) / 32;

   logic [31:0]            state;
   logic [31:0]            s_c;
   logic [31:0]            nxt_c;
   logic [2*WORDS*32-1:0]  stream_c;

   // Unroll the words consumed this cycle; nxt_c is the state after all of them
   always_comb begin
      s_c      = state;
      stream_c = '0;
      for (int i = 0; i < int'(2 * WORDS); i++) begin
         stream_c[i*32 +: 32] = s_c;
         s_c = lfsr_next(s_c);
      end
      nxt_c = s_c;
   end

   assign rnd_a_c = stream_c[N-1:0];
   assign rnd_b_c = stream_c[WORDS*32 +: N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       state <= SEED;
      else if (load)  state <= SEED;
      else if (step)  state <= nxt_c;
   end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: sweeps every op with directed and LFSR operands and
// compares DUT against the behavioural ALU, counting mismatches.
module alu_bist
   import alu_types_pkg::*;
   import alu_bist_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned N_RAND  = 1000,
   parameter int unsigned MAX_ERR = 10,
   parameter logic [31:0] SEED    = 32'hACE1_2021,
   parameter int unsigned CW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          aborted,
   output logic [N-1:0]  a,
   output logic [N-1:0]  b,
   output alu_control_t  control,
   input  logic [N-1:0]  dut_result,
   input  logic          dut_overflow,
   input  logic          dut_zero,
   input  logic          dut_equal,
   input  logic [N-1:0]  ref_result,
   input  logic          ref_overflow,
   input  logic          ref_zero,
   input  logic          ref_equal,
   output logic [CW-1:0] err_total,
   input  logic [3:0]    err_sel,
   output logic [CW-1:0] err_op_count
);

   localparam int unsigned JW  = $clog2(N_VEC);
   localparam int unsigned RW  = (N_RAND > 1) ? $clog2(N_RAND) : 1;
   localparam int unsigned OPN = 2 ** $bits(alu_control_t);

   bist_state_t   state, state_d;
   logic [JW-1:0] j, j_d, k, k_d;
   logic [RW-1:0] rcnt, rcnt_d;
   logic          vld, vld_d;
   logic [N-1:0]  a_d, b_d;
   alu_control_t  control_d;
   logic          busy_d, done_d, pass_d, aborted_d;
   logic [CW-1:0] err_total_d;
   logic [CW-1:0] op_cnt   [OPN];
   logic [CW-1:0] op_cnt_d [OPN];

   logic          lfsr_load_c, lfsr_step_c;
   logic [N-1:0]  rnd_a_c, rnd_b_c;
   logic          run_c, abort_c, res_mis_c;
   logic [2:0]    mis_c;

   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] x, input logic [2:0] inc);
      logic [CW:0] s;
      s = (CW+1)'(x) + (CW+1)'(inc);
      return s[CW] ? '1 : s[CW-1:0];
   endfunction

   alu_bist_lfsr #(.N(N), .SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load_c),
      .step    (lfsr_step_c),
      .rnd_a_c (rnd_a_c),
      .rnd_b_c (rnd_b_c)
   );

   // Case-inequality so X/Z on either ALU counts as a mismatch
   assign res_mis_c = (dut_result !== ref_result);
   assign mis_c     = 3'(dut_zero !== ref_zero) + 3'(dut_equal !== ref_equal)
                    + 3'(dut_overflow !== ref_overflow) + 3'(res_mis_c);
   assign run_c     = (state == DIR) || (state == RAND) || (state == NXT) || (state == DRAIN);
   assign abort_c   = run_c && (32'(err_total) > MAX_ERR);

   assign err_op_count = op_cnt[err_sel];

   always_comb begin
      state_d     = state;
      j_d         = j;
      k_d         = k;
      rcnt_d      = rcnt;
      vld_d       = 1'b0;
      a_d         = a;
      b_d         = b;
      control_d   = control;
      aborted_d   = aborted;
      err_total_d = err_total;
      op_cnt_d    = op_cnt;
      lfsr_load_c = 1'b0;
      lfsr_step_c = 1'b0;

      // vld marks that a/b/control were issued last edge; the in-flight vector at abort is dropped
      if (vld && !abort_c) begin
         err_total_d = sat_add(err_total, mis_c);
         if (res_mis_c) op_cnt_d[control] = sat_add(op_cnt[control], 3'd1);
      end

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d     = DIR;
               j_d         = '0;
               k_d         = '0;
               control_d   = control.first();
               aborted_d   = 1'b0;
               err_total_d = '0;
               op_cnt_d    = '{default: '0};
               lfsr_load_c = 1'b1;
            end
         end
         DIR: begin
            a_d   = N'(ALU_BIST_VECTORS[j]);
            b_d   = N'(ALU_BIST_VECTORS[k]);
            vld_d = 1'b1;
            if (k == JW'(N_VEC - 1)) begin
               k_d = '0;
               if (j == JW'(N_VEC - 1)) begin
                  j_d     = '0;
                  rcnt_d  = '0;
                  state_d = RAND;
               end else begin
                  j_d = j + JW'(1);
               end
            end else begin
               k_d = k + JW'(1);
            end
         end
         RAND: begin
            a_d         = rnd_a_c;
            b_d         = rnd_b_c;
            vld_d       = 1'b1;
            lfsr_step_c = 1'b1;
            if (rcnt == RW'(N_RAND - 1)) state_d = NXT;
            else                         rcnt_d  = rcnt + RW'(1);
         end
         NXT: begin
            if (control == control.last()) begin
               state_d = DRAIN;
            end else begin
               control_d = control.next();
               state_d   = DIR;
            end
         end
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase

      if (abort_c) begin
         state_d   = DONE;
         aborted_d = 1'b1;
         vld_d     = 1'b0;
      end

      busy_d = state_d inside {DIR, RAND, NXT, DRAIN};
      done_d = (state_d == DONE);
      pass_d = done_d && !aborted_d && (err_total_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         j         <= '0;
         k         <= '0;
         rcnt      <= '0;
         vld       <= 1'b0;
         a         <= '0;
         b         <= '0;
         control   <= control.first();
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         aborted   <= 1'b0;
         err_total <= '0;
         op_cnt    <= '{default: '0};
      end else begin
         state     <= state_d;
         j         <= j_d;
         k         <= k_d;
         rcnt      <= rcnt_d;
         vld       <= vld_d;
         a         <= a_d;
         b         <= b_d;
         control   <= control_d;
         busy      <= busy_d;
         done      <= done_d;
         pass      <= pass_d;
         aborted   <= aborted_d;
         err_total <= err_total_d;
         op_cnt    <= op_cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: three sequencers around a behavioural ALU with selectable faults.
module tb_alu_bist;
   import alu_types_pkg::*;

   localparam int NV   = 10;
   localparam int NR   = 1000;
   localparam int PER  = NV * NV + NR;
   localparam int PER1 = PER + 1;

   typedef struct packed {
      logic [31:0] r;
      logic        ov;
      logic        z;
      logic        eq;
   } alu_out_t;

   logic clk, rst;
   logic start0, start1, start2;
   int   fault0, fault1, fault2;

   logic         busy0, done0, pass0, aborted0;
   logic [31:0]  a0, b0;
   alu_control_t ctl0;
   logic [15:0]  err_total0, err_op_count0;
   logic [3:0]   err_sel0;
   alu_out_t     ref0, dut0;

   logic         busy1, done1, pass1, aborted1;
   logic [31:0]  a1, b1;
   alu_control_t ctl1;
   logic [15:0]  err_total1, err_op_count1;
   logic [3:0]   err_sel1;
   alu_out_t     ref1, dut1;

   logic         busy2, done2, pass2, aborted2;
   logic [31:0]  a2, b2;
   alu_control_t ctl2;
   logic [3:0]   err_total2, err_op_count2;
   logic [3:0]   err_sel2;
   alu_out_t     ref2, dut2;

   int checks = 0;
   int errors = 0;
   int nops, zexp, bc, se, rs;

   logic [31:0]  vec [NV] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA, 32'd31, 32'd32,
                              32'hFFFF_FFFE};
   logic [31:0]  exp_a [$];
   logic [31:0]  exp_b [$];
   alu_control_t exp_c [$];

   function automatic alu_out_t alu_model(input alu_control_t c, input logic [31:0] x, input logic [31:0] y);
      alu_out_t o;
      o = '0;
      case (c)
         ALU_AND: o.r = x & y;
         ALU_OR:  o.r = x | y;
         ALU_ADD: begin o.r = x + y; o.ov = (x[31] == y[31]) && (o.r[31] != x[31]); end
         ALU_SUB: begin o.r = x - y; o.ov = (x[31] != y[31]) && (o.r[31] != x[31]); end
         ALU_XOR: o.r = x ^ y;
         ALU_NOR: o.r = ~(x | y);
         default: o.r = '0;
      endcase
      o.z  = (o.r == 32'd0);
      o.eq = (x == y);
      return o;
   endfunction

   // 1: ADD result forced to 0; 2: zero flag stuck at 0; 3: every field inverted
   function automatic alu_out_t inject(input int f, input alu_control_t c, input alu_out_t o);
      alu_out_t r;
      r = o;
      case (f)
         1: if (c == ALU_ADD) r.r = '0;
         2: r.z = 1'b0;
         3: r = ~o;
         default: r = o;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   assign ref0 = alu_model(ctl0, a0, b0);
   assign dut0 = inject(fault0, ctl0, ref0);
   assign ref1 = alu_model(ctl1, a1, b1);
   assign dut1 = inject(fault1, ctl1, ref1);
   assign ref2 = alu_model(ctl2, a2, b2);
   assign dut2 = inject(fault2, ctl2, ref2);

   alu_bist u_bist0 (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
      .aborted(aborted0), .a(a0), .b(b0), .control(ctl0),
      .dut_result(dut0.r), .dut_overflow(dut0.ov), .dut_zero(dut0.z), .dut_equal(dut0.eq),
      .ref_result(ref0.r), .ref_overflow(ref0.ov), .ref_zero(ref0.z), .ref_equal(ref0.eq),
      .err_total(err_total0), .err_sel(err_sel0), .err_op_count(err_op_count0)
   );

   alu_bist #(.MAX_ERR(1000)) u_bist1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
      .aborted(aborted1), .a(a1), .b(b1), .control(ctl1),
      .dut_result(dut1.r), .dut_overflow(dut1.ov), .dut_zero(dut1.z), .dut_equal(dut1.eq),
      .ref_result(ref1.r), .ref_overflow(ref1.ov), .ref_zero(ref1.z), .ref_equal(ref1.eq),
      .err_total(err_total1), .err_sel(err_sel1), .err_op_count(err_op_count1)
   );

   alu_bist #(.CW(4), .MAX_ERR(100)) u_bist2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
      .aborted(aborted2), .a(a2), .b(b2), .control(ctl2),
      .dut_result(dut2.r), .dut_overflow(dut2.ov), .dut_zero(dut2.z), .dut_equal(dut2.eq),
      .ref_result(ref2.r), .ref_overflow(ref2.ov), .ref_zero(ref2.z), .ref_equal(ref2.eq),
      .err_total(err_total2), .err_sel(err_sel2), .err_op_count(err_op_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input alu_control_t c, input logic [31:0] x, input logic [31:0] y);
      alu_out_t o;
      exp_c.push_back(c);
      exp_a.push_back(x);
      exp_b.push_back(y);
      o = alu_model(c, x, y);
      if (o.z) zexp++;
   endtask

   // Runs bench instance 0 from a start pulse; optional extra start pulses and a mid-run reset
   task automatic run0(input int rst_at, input int st_a, input int st_b,
                       output int busy_cnt, output int stim_err, output int rises);
      int   done_c, n;
      logic prev;
      busy_cnt = 0; stim_err = 0; rises = 0; done_c = -1; prev = 1'b0;
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         if (c == rst_at) begin
            rst = 1'b0;
            #1;
            check("rst_busy", 64'(busy0), 64'd0);
            check("rst_done", 64'(done0), 64'd0);
            check("rst_pass", 64'(pass0), 64'd0);
            check("rst_aborted", 64'(aborted0), 64'd0);
            check("rst_a", 64'(a0), 64'd0);
            check("rst_b", 64'(b0), 64'd0);
            check("rst_err_total", 64'(err_total0), 64'd0);
            check("rst_control", 64'(ctl0), 64'(ALU_AND));
            rst = 1'b1;
            return;
         end
         if (busy0) busy_cnt++;
         if (c >= 1 && ((c - 1) % PER1) < PER && ((c - 1) / PER1) < nops) begin
            n = ((c - 1) / PER1) * PER + (c - 1) % PER1;
            if (a0 !== exp_a[n] || b0 !== exp_b[n] || ctl0 !== exp_c[n]) stim_err++;
         end
         if (done0 && !prev) begin
            rises++;
            if (done_c < 0) done_c = c;
         end
         prev = done0;
         if (done_c >= 0 && c >= done_c + 4) break;
         start0 = (c == st_a) || (c == st_b);
         @(posedge clk); #1;
      end
      start0 = 1'b0;
   endtask

   task automatic run_aux(input int which);
      @(posedge clk); #1;
      if (which == 1) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      if (which == 1) start1 = 1'b0; else start2 = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         if ((which == 1) ? done1 : done2) break;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      alu_control_t c;
      logic [31:0]  s, av, bv;

      c = c.first(); s = 32'hACE1_2021; nops = 0; zexp = 0;
      do begin
         for (int j = 0; j < NV; j++)
            for (int k = 0; k < NV; k++) push_exp(c, vec[j], vec[k]);
         for (int r = 0; r < NR; r++) begin
            av = s; s = lfsr_step(s);
            bv = s; s = lfsr_step(s);
            push_exp(c, av, bv);
         end
         nops++;
         c = c.next();
      end while (c != c.first());

      rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      fault0 = 0; fault1 = 2; fault2 = 3;
      err_sel0 = '0; err_sel1 = '0; err_sel2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy0), 64'd0);
      check("reset_done", 64'(done0), 64'd0);
      check("reset_pass", 64'(pass0), 64'd0);
      check("reset_a", 64'(a0), 64'd0);
      check("reset_err_total", 64'(err_total0), 64'd0);
      check("reset_control", 64'(ctl0), 64'(ALU_AND));
      rst = 1'b1;

      // Good DUT alongside zero-stuck and always-wrong DUTs
      fork
         run0(-1, -1, -1, bc, se, rs);
         run_aux(1);
         run_aux(2);
      join
      check("good_busy_cycles", 64'(bc), 64'(nops * PER1 + 1));
      check("good_stimulus", 64'(se), 64'd0);
      check("good_done", 64'(done0), 64'd1);
      check("good_pass", 64'(pass0), 64'd1);
      check("good_aborted", 64'(aborted0), 64'd0);
      check("good_err_total", 64'(err_total0), 64'd0);
      check("zero_done", 64'(done1), 64'd1);
      check("zero_pass", 64'(pass1), 64'd0);
      check("zero_aborted", 64'(aborted1), 64'd0);
      check("zero_err_total", 64'(err_total1), 64'(zexp));
      for (int e = 0; e < 16; e++) begin
         err_sel1 = 4'(e);
         #1;
         check("zero_op_count", 64'(err_op_count1), 64'd0);
      end
      check("sat_done", 64'(done2), 64'd1);
      check("sat_aborted", 64'(aborted2), 64'd0);
      check("sat_pass", 64'(pass2), 64'd0);
      check("sat_err_total", 64'(err_total2), 64'd15);
      err_sel2 = 4'(ALU_ADD);
      #1;
      check("sat_op_count_add", 64'(err_op_count2), 64'd15);

      // start while busy and in the drain cycle
      run0(-1, 300, nops * PER1, bc, se, rs);
      check("restart_done_rises", 64'(rs), 64'd1);
      check("restart_busy_cycles", 64'(bc), 64'(nops * PER1 + 1));
      check("restart_stimulus", 64'(se), 64'd0);
      check("restart_done", 64'(done0), 64'd1);
      check("restart_pass", 64'(pass0), 64'd1);

      // reset mid-run, then a fresh run must replay the same stimulus
      run0(500, -1, -1, bc, se, rs);
      repeat (5) @(posedge clk);
      #1;
      check("after_rst_done", 64'(done0), 64'd0);
      check("after_rst_busy", 64'(busy0), 64'd0);
      run0(-1, -1, -1, bc, se, rs);
      check("rerun_stimulus", 64'(se), 64'd0);
      check("rerun_pass", 64'(pass0), 64'd1);

      // ADD result forced to zero aborts once err_total reaches 11
      fault0 = 1;
      run0(-1, -1, -1, bc, se, rs);
      check("abort_done", 64'(done0), 64'd1);
      check("abort_aborted", 64'(aborted0), 64'd1);
      check("abort_pass", 64'(pass0), 64'd0);
      check("abort_err_total", 64'(err_total0), 64'd11);
      for (int e = 0; e < 16; e++) begin
         err_sel0 = 4'(e);
         #1;
         check("abort_op_count", 64'(err_op_count0), (e == int'(ALU_ADD)) ? 64'd11 : 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
